// File: rtl/joy_serial_scan.sv
// Serial pad-chain scanner: drives load/clock to a PISO chain, deserialises the
// active-low stream and publishes filtered per-player buttons plus presence.
module joy_serial_scan #(
  parameter int PLAYERS  = 2,
  parameter int BITS     = 12,
  parameter int CLK_DIV  = 12,
  parameter int MARK_BIT = 11,
  parameter int FILTER   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load,
  output logic [PLAYERS*BITS-1:0]   joy_out,
  output logic [PLAYERS-1:0]        present,
  output logic                      frame_strobe
);
  localparam int N  = PLAYERS * BITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   div;
  logic            tick;
  logic [BW-1:0]   bitcnt, bitcnt_n;
  logic [N-1:0]    raw, raw_n, prev, prev_n;
  logic            clk_n, load_n, strobe_n;
  logic [N-1:0]    out_n, joy_dec;
  logic [PLAYERS-1:0] pres_n, pres_dec;

  assign tick = (div == CW'(CLK_DIV - 1));

  // A pad with its marker bit high is treated as unplugged and reads as idle.
  for (genvar p = 0; p < PLAYERS; p++) begin : g_dec
    assign pres_dec[p]               = ~raw[p*BITS + MARK_BIT];
    assign joy_dec[p*BITS +: BITS]   = pres_dec[p] ? ~raw[p*BITS +: BITS] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div          <= '0;
      bitcnt       <= '0;
      raw          <= '0;
      prev         <= '0;
      joy_clk      <= 1'b0;
      joy_load     <= 1'b1;
      joy_out      <= '0;
      present      <= '0;
      frame_strobe <= 1'b0;
    end else begin
      state        <= state_n;
      div          <= tick ? '0 : div + 1'b1;
      bitcnt       <= bitcnt_n;
      raw          <= raw_n;
      prev         <= prev_n;
      joy_clk      <= clk_n;
      joy_load     <= load_n;
      joy_out      <= out_n;
      present      <= pres_n;
      frame_strobe <= strobe_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    raw_n    = raw;
    prev_n   = prev;
    clk_n    = joy_clk;
    load_n   = joy_load;
    out_n    = joy_out;
    pres_n   = present;
    strobe_n = 1'b0;
    case (state)
      IDLE: if (tick && enable) begin
        state_n = LOAD;
        load_n  = 1'b0;
      end
      LOAD: if (tick) begin
        state_n  = SHIFT;
        load_n   = 1'b1;
        bitcnt_n = '0;
      end
      SHIFT: if (tick) begin
        if (!joy_clk) begin
          raw_n[bitcnt] = joy_data;
          // Last bit is sampled without a trailing clock edge, so joy_clk ends low.
          if (bitcnt == BW'(N - 1)) state_n = DONE;
          else begin
            bitcnt_n = bitcnt + 1'b1;
            clk_n    = 1'b1;
          end
        end else begin
          clk_n = 1'b0;
        end
      end
      DONE: begin
        strobe_n = 1'b1;
        prev_n   = raw;
        if (FILTER == 0 || raw == prev) begin
          out_n  = joy_dec;
          pres_n = pres_dec;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_joy_serial_scan.sv
// Scoreboard bench: stimulus pushes hand-computed per-frame results, a monitor
// pops and checks them on every frame_strobe along with frame-shape counts.
module tb_joy_serial_scan;
  logic       clk = 1'b0;
  logic       reset, enable;
  logic       joy_data, joy_clk, joy_load, frame_strobe;
  logic [7:0] joy_out;
  logic [1:0] present;

  typedef struct packed { logic [7:0] joy; logic [1:0] pres; } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;
  int load_lo = 0, rises = 0, loads = 0;
  logic prev_clk = 1'b0, prev_load = 1'b1, prev_strobe = 1'b0;

  logic [3:0] pad0 = 4'hF, pad1 = 4'hF;
  logic [7:0] sr = 8'hFF;
  logic       pclk_d = 1'b0;

  always #5 clk = ~clk;

  joy_serial_scan #(.PLAYERS(2), .BITS(4), .CLK_DIV(2), .MARK_BIT(3), .FILTER(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .joy_data(joy_data),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_out(joy_out),
    .present(present), .frame_strobe(frame_strobe)
  );

  // Pad chain: 8-bit PISO, player 0 bit 0 comes out first, ones shift in.
  always @(posedge clk) begin
    pclk_d <= joy_clk;
    if (!joy_load) sr <= {pad1, pad0};
    else if (joy_clk && !pclk_d) sr <= {1'b1, sr[7:1]};
  end
  assign joy_data = sr[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      load_lo = 0; rises = 0;
    end else begin
      if (!joy_load) load_lo++;
      if (!joy_load && prev_load) loads++;
      if (joy_clk && !prev_clk) rises++;
      if (prev_strobe) chk("strobe_width", {31'd0, frame_strobe}, 32'd0);
      if (frame_strobe) begin
        if (q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("joy_out", {24'd0, joy_out}, {24'd0, e.joy});
          chk("present", {30'd0, present}, {30'd0, e.pres});
        end
        chk("load_low_clks", load_lo, 32'd2);
        chk("clk_rises", rises, 32'd7);
        chk("clk_ends_low", {31'd0, joy_clk}, 32'd0);
        load_lo = 0; rises = 0;
      end
    end
    prev_clk = joy_clk; prev_load = joy_load; prev_strobe = frame_strobe;
  end

  task automatic wait_strobe();
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_strobe && n < 400);
    if (!frame_strobe) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [3:0] a, input logic [3:0] b,
                           input logic [7:0] ej, input logic [1:0] ep);
    exp_t e;
    pad0 = a; pad1 = b;
    e.joy = ej; e.pres = ep;
    q.push_back(e);
    wait_strobe();
  endtask

  initial begin
    int l0, n;
    reset = 1'b1; enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_state", {joy_clk, joy_load, joy_out, present, frame_strobe},
          {1'b0, 1'b1, 8'h00, 2'b00, 1'b0});
    end
    reset = 1'b0; enable = 1'b1;

    // Two identical frames needed before outputs move.
    run_frame(4'b0110, 4'b0011, 8'h00,        2'b00);
    run_frame(4'b0110, 4'b0011, 8'b1100_1001, 2'b11);
    // Pad 1 unplugged.
    run_frame(4'b0110, 4'b1111, 8'b1100_1001, 2'b11);
    run_frame(4'b0110, 4'b1111, 8'b0000_1001, 2'b01);
    // One-frame glitch on pad 0 is filtered out.
    run_frame(4'b0100, 4'b1111, 8'b0000_1001, 2'b01);
    run_frame(4'b0110, 4'b1111, 8'b0000_1001, 2'b01);
    // Same change held two frames is accepted.
    run_frame(4'b0100, 4'b1111, 8'b0000_1001, 2'b01);
    run_frame(4'b0100, 4'b1111, 8'b0000_1011, 2'b01);
    // Pad 1 plugged back in.
    run_frame(4'b0100, 4'b0011, 8'b0000_1011, 2'b01);
    run_frame(4'b0100, 4'b0011, 8'b1100_1011, 2'b11);

    // enable drops mid-frame: frame still completes, then no new load.
    n = 0;
    while (joy_load && n < 200) begin @(negedge clk); n++; end
    chk("load_seen", {31'd0, joy_load}, 32'd0);
    q.push_back('{joy: 8'b1100_1011, pres: 2'b11});
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_strobe();
    l0 = loads;
    repeat (150) @(negedge clk);
    chk("no_load_after_disable", loads, l0);

    // Reset mid-frame after the third shift clock.
    pad0 = 4'b0110; pad1 = 4'b0011;
    enable = 1'b1;
    n = 0;
    while (rises < 3 && n < 400) begin @(negedge clk); n++; end
    chk("reached_rise3", (rises >= 3) ? 32'd1 : 32'd0, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midframe_reset", {joy_clk, joy_load, joy_out, present},
        {1'b0, 1'b1, 8'h00, 2'b00});
    @(negedge clk);
    reset = 1'b0;
    run_frame(4'b0110, 4'b0011, 8'h00,        2'b00);
    run_frame(4'b0110, 4'b0011, 8'b1100_1001, 2'b11);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
